// File: rtl/mul_pkg.sv
// Shared Booth radix-4 encoding types and decode helper for the sequential
// controller and the parallel partial-product generator.
package mul_pkg;

   typedef enum logic [2:0] {
      BD_ZERO,
      BD_POS1,
      BD_POS2,
      BD_NEG1,
      BD_NEG2
   } booth_digit_e;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } ctrl_state_e;

   function automatic booth_digit_e booth_decode(input logic [2:0] triplet);
      booth_digit_e d;
      case (triplet)
         3'b001, 3'b010: d = BD_POS1;
         3'b011:         d = BD_POS2;
         3'b100:         d = BD_NEG2;
         3'b101, 3'b110: d = BD_NEG1;
         default:        d = BD_ZERO;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/booth_seq_mul_ctrl_pp_select.sv
// Combinational Booth partial-product select: maps one triplet and the
// sign-extended multiplicand to 0, +/-A or +/-2A at 2*WIDTH bits.
module booth_pp_select
   import mul_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]         i_triplet,
   input  logic [2*WIDTH-1:0] i_a_ext,
   output logic [2*WIDTH-1:0] o_pp
);

   booth_digit_e w_digit;

   always_comb begin
      w_digit = booth_decode(i_triplet);
      o_pp    = '0;
      case (w_digit)
         BD_POS1: o_pp = i_a_ext;
         BD_POS2: o_pp = i_a_ext << 1;
         BD_NEG1: o_pp = -i_a_ext;
         BD_NEG2: o_pp = -(i_a_ext << 1);
         default: o_pp = '0;
      endcase
   end

endmodule

// File: rtl/booth_seq_mul_ctrl.sv
// Sequential radix-4 Booth multiplier: one partial product per cycle into a
// 2*WIDTH accumulator, with valid/ready handshakes on operands and product.
module booth_seq_mul_ctrl
   import mul_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               abort,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int DIGITS = WIDTH / 2;
   localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   ctrl_state_e          r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [2*WIDTH-1:0]   r_a_sh;
   logic [WIDTH:0]       r_b_sh;
   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   r_product;
   logic                 r_out_valid;
   logic [2*WIDTH-1:0]   w_pp;
   logic [2*WIDTH-1:0]   w_acc_nxt;

   // A is pre-shifted by 2 per digit and b_ext shifted down, so the current
   // triplet always sits at b_sh[2:0] and the PP needs no variable shifter.
   booth_pp_select #(.WIDTH(WIDTH)) u_pp_select (
      .i_triplet (r_b_sh[2:0]),
      .i_a_ext   (r_a_sh),
      .o_pp      (w_pp)
   );

   assign w_acc_nxt = r_acc + w_pp;
   assign in_ready  = (r_state == IDLE);
   assign busy      = (r_state != IDLE);
   assign out_valid = r_out_valid;
   assign product   = r_product;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_a_sh      <= '0;
         r_b_sh      <= '0;
         r_acc       <= '0;
         r_product   <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid && !abort) begin
                  r_a_sh  <= {{WIDTH{a[WIDTH-1]}}, a};
                  r_b_sh  <= {b, 1'b0};
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_state <= CALC;
               end
            end
            CALC: begin
               if (abort) begin
                  r_state <= IDLE;
               end else begin
                  r_acc  <= w_acc_nxt;
                  r_a_sh <= r_a_sh << 2;
                  r_b_sh <= r_b_sh >> 2;
                  r_cnt  <= r_cnt + 1'b1;
                  if (r_cnt == CNT_W'(DIGITS - 1)) begin
                     r_product   <= w_acc_nxt;
                     r_out_valid <= 1'b1;
                     r_state     <= DONE;
                  end
               end
            end
            DONE: begin
               if (abort || out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

endmodule
